// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Produces packed BCD digits, a leading-zero blanking mask and an overflow
// flag; the visible result only changes on commit, never mid-conversion.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic                  overflow
);

    localparam int BW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);
    // Blanking mask of the value zero: every digit blank except digit 0.
    localparam logic [DIGITS-1:0] BLANK_ZERO = ~DIGITS'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_out_q, bcd_out_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [BW-1:0]       shift_bcd;
    logic [WIDTH-1:0]    shift_bin;
    logic                spill;
    logic [DIGITS-1:0]   blank_shift;
    logic                zero_above;

    // Add-3 correction on every nibble that would exceed 9 after doubling.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    (bcd_q[gi*4 +: 4] + 4'd3) :
                                    bcd_q[gi*4 +: 4];
        end
    endgenerate

    // The top bit of the corrected accumulator is lost by the shift; if it
    // is ever set, the value needs more digits than are available.
    assign shifted   = {adj, bin_q} << 1;
    assign shift_bcd = shifted[BW+WIDTH-1:WIDTH];
    assign shift_bin = shifted[WIDTH-1:0];
    assign spill     = adj[BW-1];

    // Leading-zero mask of the value about to be committed (digit 0 never blank).
    always_comb begin
        blank_shift = '0;
        zero_above  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above     = zero_above & (shift_bcd[i*4 +: 4] == 4'd0);
            blank_shift[i] = zero_above;
        end
    end

    // Next-state and datapath control for the two-state converter.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        bcd_out_d = bcd_out_q;
        blank_d   = blank_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    bcd_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bin_d     = shift_bin;
                bcd_d     = shift_bcd;
                ovf_acc_d = ovf_acc_q | spill;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_acc_d;
                    if (ovf_acc_d) begin
                        bcd_out_d = {DIGITS{4'h9}};
                        blank_d   = '0;
                    end else begin
                        bcd_out_d = shift_bcd;
                        blank_d   = blank_shift;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            bcd_out_q <= '0;
            blank_q   <= BLANK_ZERO;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            bcd_out_q <= bcd_out_d;
            blank_q   <= blank_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign bcd_out   = bcd_out_q;
    assign blank_out = blank_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: an 8-bit and a 16-bit instance, each checked
// every cycle against a transaction-level decimal model, plus directed cases.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start8, start16;
    logic [7:0]  bin8;
    logic [15:0] bin16;
    logic        busy8, done8, ovf8, busy16, done16, ovf16;
    logic [15:0] bcd8, bcd16;
    logic [3:0]  blank8, blank16;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(4)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8), .blank_out(blank8),
        .overflow(ovf8));

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .bin_in(bin16),
        .busy(busy16), .done(done16), .bcd_out(bcd16), .blank_out(blank16),
        .overflow(ovf16));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: digits by repeated division, blanking by magnitude.
    task automatic to_bcd(input int unsigned v, output logic [15:0] bcd,
                          output logic [3:0] blank, output bit ovf);
        int unsigned r;
        int unsigned p;
        bcd   = '0;
        blank = '0;
        ovf   = (v >= 10000);
        if (ovf) begin
            bcd = 16'h9999;
        end else begin
            r = v;
            for (int i = 0; i < 4; i++) begin
                bcd[i*4 +: 4] = 4'(r % 10);
                r = r / 10;
            end
            p = 10;
            for (int i = 1; i < 4; i++) begin
                blank[i] = (v < p);
                p = p * 10;
            end
        end
    endtask

    // Transaction model: accept when idle, commit WIDTH edges later.
    bit          m_active [2];
    int          m_commit [2];
    int unsigned m_val    [2];
    logic [15:0] e_bcd    [2];
    logic [3:0]  e_blank  [2];
    bit          e_ovf    [2];
    bit          e_busy   [2];
    bit          e_done   [2];
    int          edge_n = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_active[k] = 1'b0;
                e_bcd[k]    = 16'h0000;
                e_blank[k]  = 4'b1110;
                e_ovf[k]    = 1'b0;
                e_busy[k]   = 1'b0;
                e_done[k]   = 1'b0;
            end
        end else begin
            edge_n++;
            for (int k = 0; k < 2; k++) begin
                e_done[k] = 1'b0;
                if (m_active[k]) begin
                    if (edge_n == m_commit[k]) begin
                        to_bcd(m_val[k], e_bcd[k], e_blank[k], e_ovf[k]);
                        e_done[k]   = 1'b1;
                        m_active[k] = 1'b0;
                    end
                end else if ((k == 0) ? start8 : start16) begin
                    m_active[k] = 1'b1;
                    m_commit[k] = edge_n + ((k == 0) ? 8 : 16);
                    m_val[k]    = (k == 0) ? 32'(bin8) : 32'(bin16);
                end
                e_busy[k] = m_active[k];
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("busy8",   32'(busy8),   32'(e_busy[0]));
                chk("done8",   32'(done8),   32'(e_done[0]));
                chk("bcd8",    32'(bcd8),    32'(e_bcd[0]));
                chk("blank8",  32'(blank8),  32'(e_blank[0]));
                chk("ovf8",    32'(ovf8),    32'(e_ovf[0]));
                chk("busy16",  32'(busy16),  32'(e_busy[1]));
                chk("done16",  32'(done16),  32'(e_done[1]));
                chk("bcd16",   32'(bcd16),   32'(e_bcd[1]));
                chk("blank16", 32'(blank16), 32'(e_blank[1]));
                chk("ovf16",   32'(ovf16),   32'(e_ovf[1]));
            end
        end
    end

    // Called at posedge+2: pulse start for one edge on instance k.
    task automatic go(input int k, input int unsigned v);
        if (k == 0) begin start8 = 1'b1; bin8 = v[7:0]; end
        else        begin start16 = 1'b1; bin16 = v[15:0]; end
        @(posedge clk); #2;
        start8 = 1'b0; start16 = 1'b0;
        bin8 = 8'($urandom); bin16 = 16'($urandom);
    endtask

    // Bounded wait for done, counting busy cycles on the way.
    task automatic wait_done(input int k, input int budget, output int busy_cnt);
        bit seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ((k == 0) ? busy8 : busy16) busy_cnt++;
            if ((k == 0) ? done8 : done16) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done%0d: no done within %0d cycles", k, budget);
        end
        @(posedge clk); #2;
    endtask

    logic [15:0] t_bcd;
    logic [3:0]  t_blank;
    bit          t_ovf;
    int          bc;
    int          pulses;
    int unsigned bb_val [3] = '{0, 7, 100};
    logic [15:0] bb_bcd [3] = '{16'h0000, 16'h0007, 16'h0100};
    logic [3:0]  bb_blk [3] = '{4'b1110, 4'b1110, 4'b1000};

    initial begin
        reset_n = 1'b0;
        start8 = 1'b0; start16 = 1'b0; bin8 = '0; bin16 = '0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_bcd8",   32'(bcd8),   32'h0000);
        chk("rst_blank8", 32'(blank8), 32'b1110);
        chk("rst_busy8",  32'(busy8),  0);
        chk("rst_done8",  32'(done8),  0);
        chk("rst_ovf8",   32'(ovf8),   0);
        chk("rst_bcd16",  32'(bcd16),  32'h0000);
        @(posedge clk); #2;

        // Pin the reference model itself with hand-computed values.
        to_bcd(255, t_bcd, t_blank, t_ovf);
        chk("model255_bcd", 32'(t_bcd), 32'h0255);
        chk("model255_blank", 32'(t_blank), 32'b1000);
        to_bcd(10000, t_bcd, t_blank, t_ovf);
        chk("model10000_bcd", 32'(t_bcd), 32'h9999);
        chk("model10000_ovf", 32'(t_ovf), 1);
        to_bcd(9999, t_bcd, t_blank, t_ovf);
        chk("model9999_blank", 32'(t_blank), 32'b0000);

        // 255: busy for exactly 8 cycles, then the committed result.
        go(0, 255);
        wait_done(0, 20, bc);
        chk("lat255_busy", 32'(bc), 8);
        chk("d255_bcd", 32'(bcd8), 32'h0255);
        chk("d255_blank", 32'(blank8), 32'b1000);
        chk("d255_ovf", 32'(ovf8), 0);

        // Back-to-back, each start raised in the done cycle.
        for (int j = 0; j < 3; j++) begin
            start8 = 1'b1; bin8 = bb_val[j][7:0];
            @(posedge clk); #2;
            start8 = 1'b0; bin8 = 8'($urandom);
            repeat (8) @(posedge clk);
            #1;
            chk("b2b_done", 32'(done8), 1);
            chk("b2b_bcd", 32'(bcd8), 32'(bb_bcd[j]));
            chk("b2b_blank", 32'(blank8), 32'(bb_blk[j]));
            #1;
        end
        @(posedge clk); #2;

        // A start while busy is dropped: one done, result of the first value.
        start8 = 1'b1; bin8 = 8'd42;
        @(posedge clk); #2;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #2 start8 = 1'b1; bin8 = 8'd99;
        @(posedge clk); #2;
        start8 = 1'b0;
        chk("ign_hold_bcd", 32'(bcd8), 32'h0100);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("ign_pulses", 32'(pulses), 1);
        chk("ign_bcd", 32'(bcd8), 32'h0042);
        @(posedge clk); #2;

        // Reset mid-conversion aborts with no done pulse.
        go(0, 200);
        wait_done(0, 20, bc);
        chk("d200_bcd", 32'(bcd8), 32'h0200);
        start8 = 1'b1; bin8 = 8'd13;
        @(posedge clk); #2;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy8), 0);
        chk("arst_bcd", 32'(bcd8), 32'h0000);
        chk("arst_blank", 32'(blank8), 32'b1110);
        chk("arst_done", 32'(done8), 0);
        chk("arst_ovf", 32'(ovf8), 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("arst_nodone", 32'(pulses), 0);
        @(posedge clk); #2;
        go(0, 13);
        wait_done(0, 20, bc);
        chk("d13_bcd", 32'(bcd8), 32'h0013);

        // 16-bit instance: last representable value and first overflow.
        go(1, 9999);
        wait_done(1, 40, bc);
        chk("lat16_busy", 32'(bc), 16);
        chk("d9999_bcd", 32'(bcd16), 32'h9999);
        chk("d9999_ovf", 32'(ovf16), 0);
        go(1, 10000);
        wait_done(1, 40, bc);
        chk("d10000_bcd", 32'(bcd16), 32'h9999);
        chk("d10000_ovf", 32'(ovf16), 1);
        chk("d10000_blank", 32'(blank16), 32'b0000);

        // Random traffic on both instances, with one reset in the middle.
        for (int c = 0; c < 600; c++) begin
            start8  = ($urandom_range(0, 2) == 0);
            start16 = ($urandom_range(0, 2) == 0);
            bin8    = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                bin16 = 16'($urandom_range(9990, 10010));
            else
                bin16 = 16'($urandom);
            if (c == 300) reset_n = 1'b0;
            if (c == 302) reset_n = 1'b1;
            @(posedge clk); #2;
        end
        start8 = 1'b0; start16 = 1'b0;
        repeat (20) @(posedge clk);
        #2 cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD encoder using iterative double-dabble, one shift per clock. It converts binary results, such as quotient or remainder from the division unit, into packed BCD digits for the display refresh block. The display block consumes and decodes BCD; this block produces it. It also generates a leading-zero blanking mask and saturates to all-nines on overflow.

Parameters:
WIDTH, 8, bit width of binary input (1..16)
DIGITS, 4, number of BCD output digits (1..5); output width is DIGITS*4

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled only in IDLE
bin_in  input  WIDTH  unsigned binary value; captured on accepted start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when a new result is committed
bcd_out  output  DIGITS*4  packed BCD result; digit 0 is bits [3:0]
blank_out  output  DIGITS  bit i=1 when digit i is a leading zero; bit 0 is never set
overflow  output  1  last committed value needed more than DIGITS digits

Behaviour:
- Reset (async, reset_n=0):
  - State returns to IDLE.
  - busy=0, done=0, overflow=0.
  - bcd_out=0.
  - blank_out = all ones except bit 0 (i.e. the blanking mask for value 0).
  - Internal shift register and counter are cleared.
  - Reset asserted mid-conversion aborts the conversion; no done pulse is produced.
- States: IDLE, SHIFT.
- IDLE:
  - done is 0 except in the cycle immediately after a commit.
  - On edge with start=1: capture bin_in into a binary shift register, clear the BCD accumulator and overflow accumulator, set counter=WIDTH, set busy=1, go to SHIFT.
  - bin_in is ignored outside the capture edge; the caller may change it freely afterwards.
- SHIFT, each edge:
  - Every BCD nibble >=5 gets +3, all nibbles in parallel.
  - Then the whole {bcd, bin} register shifts left by 1.
  - The bit shifted out of the top nibble is ORed into the overflow accumulator.
  - counter decrements.
- Commit (edge where counter goes 1->0):
  - bcd_out, blank_out, and overflow update.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency:
  - start sampled at edge E0; result and done are visible after edge E_WIDTH.
  - This is WIDTH cycles; with defaults, 8 cycles.
  - busy is high for exactly WIDTH cycles.
- Throughput:
  - A start in the cycle where done=1 is accepted, since the block is in IDLE.
  - Back-to-back conversions take WIDTH+1 cycles apart.
- start while busy=1 is ignored: not queued and no error.
- bcd_out holds the previous result during a conversion; it never shows partial values, so the display sees no glitch.
- Overflow: if the overflow accumulator is set at commit, overflow=1, bcd_out = all digits 9, and blank_out = 0. Otherwise overflow=0.
- blank_out: bit i (i>=1) is 1 iff digit i and all higher digits of the committed bcd_out are 0.
- Arithmetic: nibble add is 4-bit; no carry between nibbles is needed, since nibble <=9 before the add step.

Test Plan:
- Reset then idle -> bcd_out=0x0000, blank_out=4'b1110, busy=0, done=0, overflow=0.
- start with bin_in=8'd255 at E0 -> busy high for 8 cycles; done pulses after E8; bcd_out=0x0255, blank_out=4'b1000, overflow=0.
- bin_in=0, then 7, then 100, issued back-to-back, each start in the done cycle -> results 0x0000/1110, 0x0007/1110, 0x0100/1000; done pulses 9 cycles apart.
- start with 8'd42; at E3 assert start with bin_in=8'd99 -> second start ignored; result 0x0042; exactly one done pulse; bcd_out stays at the prior value until commit.
- Convert 8'd200, then pull reset_n low at E4 of a conversion of 8'd13 -> outputs return to reset values asynchronously; no done pulse; next start of 8'd13 yields 0x0013.
- Instance with WIDTH=16, DIGITS=4: bin_in=16'd9999 -> 0x9999, overflow=0; bin_in=16'd10000 -> bcd_out=0x9999, overflow=1, blank_out=0; done after 16 cycles.
